// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with BCD digit outputs; decrements once per TICKS_PER_SEC clocks.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the stored preset on expiry instead of halting.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic [3:0] sec_first,
    output logic [3:0] sec_second,
    output logic [3:0] min_first,
    output logic [3:0] min_second,
    output logic [3:0] hour_first,
    output logic [3:0] hour_second,
    output logic       one_sec,
    output logic       running,
    output logic       expired
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_SEC - 1);

    logic [1:0]       state_q, state_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [4:0]       pre_hour_q, pre_hour_d;
    logic [5:0]       pre_min_q, pre_min_d;
    logic [5:0]       pre_sec_q, pre_sec_d;
    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic             one_sec_q, one_sec_d;
    logic             running_q;
    logic             expired_q, expired_d;
    logic             reload_pulse;

    logic [4:0] sat_hour;
    logic [5:0] sat_min;
    logic [5:0] sat_sec;
    logic [4:0] dec_hour;
    logic [5:0] dec_min;
    logic [5:0] dec_sec;
    logic       time_zero;
    logic       dec_zero;
    logic       tick;

    assign sat_hour  = (set_hour > 5'd23) ? 5'd23 : set_hour;
    assign sat_min   = (set_min  > 6'd59) ? 6'd59 : set_min;
    assign sat_sec   = (set_sec  > 6'd59) ? 6'd59 : set_sec;
    assign time_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);
    assign tick      = (state_q == ST_RUN) && (prescaler_q == LAST_TICK);

    // Borrow cascade: seconds first, then minutes, then hours; never goes below zero.
    always_comb begin
        dec_hour = hour_q;
        dec_min  = min_q;
        dec_sec  = sec_q;
        if (sec_q != 6'd0) begin
            dec_sec = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
            dec_min = min_q - 6'd1;
            dec_sec = 6'd59;
        end else if (hour_q != 5'd0) begin
            dec_hour = hour_q - 5'd1;
            dec_min  = 6'd59;
            dec_sec  = 6'd59;
        end
    end

    assign dec_zero = (dec_hour == 5'd0) && (dec_min == 6'd0) && (dec_sec == 6'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic preset_zero;
    assign preset_zero = (pre_hour_q == 5'd0) && (pre_min_q == 6'd0) && (pre_sec_q == 6'd0);
`else
    logic preset_unused;
    assign preset_unused = ^{pre_hour_q, pre_min_q, pre_sec_q};
`endif

    always_comb begin
        state_d      = state_q;
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        pre_hour_d   = pre_hour_q;
        pre_min_d    = pre_min_q;
        pre_sec_d    = pre_sec_q;
        prescaler_d  = prescaler_q;
        one_sec_d    = 1'b0;
        reload_pulse = 1'b0;

        if (clear) begin
            state_d     = ST_IDLE;
            hour_d      = 5'd0;
            min_d       = 6'd0;
            sec_d       = 6'd0;
            prescaler_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        hour_d = sat_hour;  min_d = sat_min;  sec_d = sat_sec;
                        pre_hour_d = sat_hour;  pre_min_d = sat_min;  pre_sec_d = sat_sec;
                    end else if (!pause && start && !time_zero) begin
                        state_d     = ST_RUN;
                        prescaler_d = '0;
                    end
                end
                ST_RUN: begin
                    // The cycle in which pause is sampled still counts, so resume keeps the phase exact.
                    if (tick) begin
                        prescaler_d = '0;
                        one_sec_d   = 1'b1;
                        hour_d      = dec_hour;
                        min_d       = dec_min;
                        sec_d       = dec_sec;
                    end else begin
                        prescaler_d = prescaler_q + 1'b1;
                    end
                    if (tick && dec_zero) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (preset_zero) begin
                            state_d = ST_EXPIRED;
                        end else begin
                            hour_d       = pre_hour_q;
                            min_d        = pre_min_q;
                            sec_d        = pre_sec_q;
                            reload_pulse = 1'b1;
                            if (pause) state_d = ST_PAUSED;
                        end
`else
                        state_d = ST_EXPIRED;
`endif
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (load) begin
                        hour_d = sat_hour;  min_d = sat_min;  sec_d = sat_sec;
                        pre_hour_d = sat_hour;  pre_min_d = sat_min;  pre_sec_d = sat_sec;
                        prescaler_d = '0;
                    end else if (!pause && start && !time_zero) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (load) begin
                        hour_d = sat_hour;  min_d = sat_min;  sec_d = sat_sec;
                        pre_hour_d = sat_hour;  pre_min_d = sat_min;  pre_sec_d = sat_sec;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign expired_d = (state_q == ST_EXPIRED) || reload_pulse;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            pre_hour_q  <= 5'd0;
            pre_min_q   <= 6'd0;
            pre_sec_q   <= 6'd0;
            prescaler_q <= '0;
            one_sec_q   <= 1'b0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            pre_hour_q  <= pre_hour_d;
            pre_min_q   <= pre_min_d;
            pre_sec_q   <= pre_sec_d;
            prescaler_q <= prescaler_d;
            one_sec_q   <= one_sec_d;
            running_q   <= (state_q == ST_RUN);
            expired_q   <= expired_d;
        end
    end

    assign sec_first   = 4'(sec_q / 6'd10);
    assign sec_second  = 4'(sec_q % 6'd10);
    assign min_first   = 4'(min_q / 6'd10);
    assign min_second  = 4'(min_q % 6'd10);
    assign hour_first  = 4'(hour_q / 5'd10);
    assign hour_second = 4'(hour_q % 5'd10);
    assign one_sec     = one_sec_q;
    assign running     = running_q;
    assign expired     = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (default build): directed literal checks plus a randomized run
// compared every cycle against a seconds-count behavioural model.
`timescale 1ns/1ps
module tb_countdown_timer;
    localparam int TPS = 4;

    logic       clk_100MHz = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0, set_sec = '0;
    logic [3:0] sec_first, sec_second, min_first, min_second, hour_first, hour_second;
    logic       one_sec, running, expired;
    logic [23:0] dut_digits;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit cmp_en = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    countdown_timer #(.TICKS_PER_SEC(TPS), .CNT_W(3)) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .start(start), .pause(pause), .clear(clear), .load(load),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .sec_first(sec_first), .sec_second(sec_second),
        .min_first(min_first), .min_second(min_second),
        .hour_first(hour_first), .hour_second(hour_second),
        .one_sec(one_sec), .running(running), .expired(expired)
    );

    assign dut_digits = {hour_first, hour_second, min_first, min_second, sec_first, sec_second};

    // Model: remaining time as a plain count of seconds, plus cycles spent running in the current second.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXP} mode_t;
    mode_t m_mode = M_IDLE;
    int m_time = 0, m_phase = 0, cap_t = 0;
    bit m_one = 0, m_run = 0, m_exp = 0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [23:0] digits_of(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, cycle, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk_100MHz or negedge reset_n);
        if (!reset_n) begin
            m_mode = M_IDLE; m_time = 0; m_phase = 0; m_one = 0; m_run = 0; m_exp = 0;
        end else begin
            cycle++;
            m_run = (m_mode == M_RUN);
            m_exp = (m_mode == M_EXP);
            m_one = 0;
            cap_t = sat(int'(set_hour), 23) * 3600 + sat(int'(set_min), 59) * 60 + sat(int'(set_sec), 59);
            if (clear) begin
                m_mode = M_IDLE; m_time = 0; m_phase = 0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (load) m_time = cap_t;
                        else if (!pause && start && m_time != 0) begin m_mode = M_RUN; m_phase = 0; end
                    end
                    M_RUN: begin
                        m_phase++;
                        if (m_phase == TPS) begin m_phase = 0; m_one = 1; m_time--; end
                        if (m_one && m_time == 0) m_mode = M_EXP;
                        else if (pause) m_mode = M_PAUSED;
                    end
                    M_PAUSED: begin
                        if (load) begin m_time = cap_t; m_phase = 0; end
                        else if (!pause && start && m_time != 0) m_mode = M_RUN;
                    end
                    default: begin
                        if (load) begin m_time = cap_t; m_mode = M_IDLE; end
                    end
                endcase
            end
        end
    end

    initial forever begin
        @(negedge clk_100MHz);
        if (cmp_en) begin
            chk("model_digits", 32'(dut_digits), 32'(digits_of(m_time)));
            chk("model_flags", 32'({one_sec, running, expired}), 32'({m_one, m_run, m_exp}));
        end
    end

    task automatic cyc(input bit st, input bit pa, input bit cl, input bit ld);
        @(negedge clk_100MHz);
        start = st; pause = pa; clear = cl; load = ld;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk_100MHz);
        chk("reset_digits", 32'(dut_digits), 32'h0);
        chk("reset_flags", 32'({one_sec, running, expired}), 32'h0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // 00:00:03 run to expiry; e is the edge index after the start edge.
        do_load(0, 0, 3);
        cyc(1, 0, 0, 0);
        for (int e = 0; e <= 14; e++) begin
            cyc(0, 0, 0, 0);
            chk("t1_one_sec", 32'(one_sec), 32'((e == 4 || e == 8 || e == 12) ? 1 : 0));
            chk("t1_sec_units", 32'(sec_second), 32'((e < 4) ? 3 : (e < 8) ? 2 : (e < 12) ? 1 : 0));
            chk("t1_running", 32'(running), 32'((e >= 1 && e <= 12) ? 1 : 0));
            chk("t1_expired", 32'(expired), 32'((e >= 13) ? 1 : 0));
        end
        cyc(0, 0, 1, 0);

        // Hour borrow.
        do_load(1, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("t2_borrow_digits", 32'(dut_digits), 32'h005959);
        chk("t2_one_sec", 32'(one_sec), 32'h1);
        cyc(0, 0, 1, 0);

        // Pause/resume phase preservation.
        do_load(0, 0, 5);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        repeat (20) cyc(0, 0, 0, 0);
        chk("t3_paused_sec", 32'(sec_second), 32'h5);
        chk("t3_paused_run", 32'(running), 32'h0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t3_resume_r0", 32'(one_sec), 32'h0);
        cyc(0, 0, 0, 0);
        chk("t3_resume_r1", 32'(one_sec), 32'h0);
        cyc(0, 0, 0, 0);
        chk("t3_resume_tick", 32'(one_sec), 32'h1);
        chk("t3_resume_sec", 32'(sec_second), 32'h4);
        cyc(0, 0, 1, 0);

        // Saturation, start with zero time, load+start and start+pause in IDLE.
        do_load(31, 63, 60);
        cyc(0, 0, 0, 0);
        chk("t4_saturate", 32'(dut_digits), 32'h235959);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("t4_zero_start_run", 32'(running), 32'h0);
        chk("t4_zero_digits", 32'(dut_digits), 32'h0);
        set_hour = 5'd0; set_min = 6'd0; set_sec = 6'd7;
        cyc(1, 0, 0, 1);
        cyc(1, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        chk("t4_idle_hold_run", 32'(running), 32'h0);
        chk("t4_idle_hold_sec", 32'(sec_second), 32'h7);
        cyc(0, 0, 1, 0);

        // Clear on a tick edge.
        do_load(0, 0, 9);
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("t5_clear_one_sec", 32'(one_sec), 32'h0);
        chk("t5_clear_digits", 32'(dut_digits), 32'h0);
        cyc(0, 0, 0, 0);
        chk("t5_clear_running", 32'(running), 32'h0);

        // Asynchronous reset mid-run.
        do_load(0, 2, 0);
        cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_areset_digits", 32'(dut_digits), 32'h0);
        chk("t6_areset_flags", 32'({one_sec, running, expired}), 32'h0);
        repeat (2) @(negedge clk_100MHz);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            set_hour = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            set_min  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
            set_sec  = 6'($urandom_range(0, 63));
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0);
        end
        repeat (4) cyc(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the team's up-counting stopwatch.
- Loads an HH:MM:SS preset, counts down once per second from the 100 MHz board clock, and flags expiry at 00:00:00.
- Drives the same six BCD digit outputs as the stopwatch, so the display mux can select either source without changes.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk_100MHz cycles per one-second decrement (benches use 4).
- CNT_W, 27, prescaler width; must satisfy 2^CNT_W >= TICKS_PER_SEC.

Ports:
- clk_100MHz  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse: begin or resume counting.
- pause  input  1  single-cycle pulse: freeze counting.
- clear  input  1  single-cycle pulse: cancel and zero the time.
- load  input  1  single-cycle pulse: capture the preset.
- set_hour  input  5  preset hours (0-23).
- set_min  input  6  preset minutes (0-59).
- set_sec  input  6  preset seconds (0-59).
- sec_first, sec_second  output  4 each  seconds tens / units (BCD).
- min_first, min_second  output  4 each  minutes tens / units.
- hour_first, hour_second  output  4 each  hours tens / units.
- one_sec  output  1  one-cycle pulse on each decrement.
- running  output  1  high while in state RUN.
- expired  output  1  high while in state EXPIRED.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state IDLE; hour/min/sec = 0; prescaler = 0.
  - All digit outputs 0; one_sec, running, expired = 0.
- Internal registers: hour (5b), min (6b), sec (6b), prescaler (CNT_W).
- Digit outputs are combinational: tens = value/10, units = value%10.
- States and transitions (input priority: clear > load > pause > start):
  - IDLE:
    - load -> capture preset, stay IDLE.
    - start with time != 0 -> RUN, prescaler cleared.
    - start with time == 0 -> ignored.
  - RUN:
    - pause -> PAUSED; prescaler holds its value.
    - load and start are ignored.
    - Prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0, one_sec pulses on that same edge, and the time decrements.
  - PAUSED:
    - start with time != 0 -> RUN, prescaler resumes from its held value.
    - load -> capture preset, clear prescaler, stay PAUSED.
  - EXPIRED:
    - load -> capture preset, go to IDLE.
    - start -> ignored.
  - Any state:
    - clear -> IDLE, time = 0, prescaler = 0.
- Load capture:
  - Each field is saturated independently: hour > 23 -> 23; min > 59 -> 59; sec > 59 -> 59.
  - The saturated preset is also stored in an internal preset register.
- Decrement rule, on a tick:
  - If sec > 0: sec - 1.
  - Else if min > 0: min - 1, sec = 59.
  - Else if hour > 0: hour - 1, min = 59, sec = 59.
- Expiry:
  - A tick that produces 00:00:00 moves the state to EXPIRED on that same edge.
  - expired and running are registered from state, so they change one cycle after the edge.
  - The time never wraps below zero.
- Timing:
  - The first decrement occurs TICKS_PER_SEC cycles after the start pulse is sampled.
  - Pause/resume preserves the sub-second phase; there is no extra lost or gained cycle.
- Simultaneous events:
  - start+pause in IDLE: pause wins, so there is no state change.
  - load+start in IDLE: load is taken, stay IDLE.
  - clear on the same cycle as a tick: clear wins, no one_sec pulse.
- Reset mid-count: everything returns to the reset values immediately; the preset register is also cleared.

Optional Feature:
- COUNTDOWN_AUTO_RELOAD_EN defined:
  - On expiry, instead of entering EXPIRED, the time is reloaded from the preset register and the block stays in RUN.
  - expired pulses high for exactly one cycle per expiry.
  - If the preset is 00:00:00, the block enters EXPIRED as normal.
- Undefined: the preset register is still stored, but expiry always holds in EXPIRED as described above.

Test Plan (TICKS_PER_SEC=4):
- Load 00:00:03, then start -> one_sec pulses at cycles 4, 8, 12 after start. sec_second reads 2, 1, 0. expired=1 and running=0 from cycle 13; digits hold 0.
- Load 01:00:00, then run one tick -> hour_second=0, min_first=5, min_second=9, sec_first=5, sec_second=9.
- Load 00:00:05, start; pause 2 cycles after start; wait 20 cycles; start again -> no change while paused. The next tick lands 2 cycles after resume (prescaler phase preserved); sec_second reads 4.
- Load with set_hour=31, set_min=63, set_sec=60 -> digits read 23:59:59. Start with time 0 after a clear -> stays IDLE, running=0.
- Mid-run: assert clear on the same cycle as a tick -> IDLE, all digits 0, no one_sec pulse. Assert reset_n low mid-run -> all outputs 0 asynchronously.
- With COUNTDOWN_AUTO_RELOAD_EN, load 00:00:02 and start -> expired pulses once at cycle 8. Time reloads to 02 and running stays 1; the next expired pulse is at cycle 16.
